// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the sequential Booth multiplier.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mul_pkg;

    // Controller states: waiting, retiring digits, one-cycle result strobe
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Number of Booth digits needed to cover WIDTH bits plus one extension bit:
    // ceil((width + 1) / digit_bits)
    function automatic int num_digits(input int width, input int digit_bits);
        return (width + digit_bits) / digit_bits;
    endfunction

    // Radix 4, 8 and 16 are the supported recodings
    function automatic bit digit_bits_legal(input int digit_bits);
        return (digit_bits >= 2) && (digit_bits <= 4);
    endfunction

endpackage

// File: rtl/booth_digit_encoder.sv
// Recodes a (DIGIT_BITS+1)-bit Booth window into sign and magnitude.
// Latency: combinational.
// Backpressure: none.
module booth_digit_encoder #(
    parameter int DIGIT_BITS = 4
) (
    input  logic [DIGIT_BITS:0]   window,
    output logic                  neg,
    output logic [DIGIT_BITS-1:0] mag
);

    localparam int D = DIGIT_BITS;

    // Digit range is -2^(D-1)..+2^(D-1), so D+1 signed bits hold it exactly
    logic [D:0] pos_part;
    logic [D:0] neg_part;
    logic [D:0] val;

    // Weighted window sum: -2^(D-1)*w[D] + w[D-1:1] + w[0], then sign/magnitude split
    always_comb begin
        pos_part = {2'b00, window[D-1:1]} + {{D{1'b0}}, window[0]};
        neg_part = {1'b0, window[D], {(D-1){1'b0}}};
        val      = pos_part - neg_part;
        neg      = val[D];
        // |val| <= 2^(D-1) < 2^D, so the low D bits of the negation are the magnitude
        mag      = neg ? ((~val[D-1:0]) + {{(D-1){1'b0}}, 1'b1}) : val[D-1:0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2^DIGIT_BITS Booth multiplier (MULT/MULTU), one digit per clock, LSD first.
// Latency: N = ceil((WIDTH+1)/DIGIT_BITS) cycles from Start edge to Done; 1..N with BOOTH_ZERO_SKIP_EN.
// Backpressure: Start is ignored while Busy; a Start during the Done cycle is accepted back-to-back.
module booth_seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGIT_BITS = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int D   = DIGIT_BITS;
    localparam int N   = num_digits(WIDTH, D);
    localparam int NB  = N * D;              // extended multiplier width
    localparam int PPW = WIDTH + D + 1;      // signed partial product width
    localparam int PW  = 2 * WIDTH;          // product width
    localparam int SW  = PW + D + 1;         // sign-extended partial product before shift
    localparam int CW  = $clog2(N + 1);

    if (!digit_bits_legal(DIGIT_BITS)) begin : g_bad_digit_bits
        $error("booth_seq_multiplier: DIGIT_BITS must be 2, 3 or 4");
    end
    if (WIDTH < 4) begin : g_bad_width
        $error("booth_seq_multiplier: WIDTH must be at least 4");
    end

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [NB:0]     bx_q;      // bit 0 holds the current window's bit k*D-1
    logic [WIDTH:0]  a_ext_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   product_q;

    logic            dig_neg;
    logic [D-1:0]    dig_mag;

    booth_digit_encoder #(
        .DIGIT_BITS (D)
    ) u_enc (
        .window (bx_q[D:0]),
        .neg    (dig_neg),
        .mag    (dig_mag)
    );

    logic signed [PPW-1:0] a_wide;
    logic signed [PPW-1:0] mag_wide;
    logic signed [PPW-1:0] pp_mag;
    logic signed [PPW-1:0] pp;
    logic [SW-1:0]         pp_ext;
    logic [PW-1:0]         pp_shift;
    logic [PW-1:0]         acc_nxt;
    logic [NB:0]           bx_nxt;
    logic [NB:0]           bx_load;
    logic [WIDTH:0]        a_load;
    logic                  last_digit;
    logic                  finish_now;
    int                    shamt;

    // Digit x A partial product, weighted by 2^(k*D) and added into the product-width accumulator
    always_comb begin
        a_wide   = {{D{a_ext_q[WIDTH]}}, a_ext_q};
        mag_wide = {{(PPW-D){1'b0}}, dig_mag};
        pp_mag   = a_wide * mag_wide;
        pp       = dig_neg ? -pp_mag : pp_mag;
        pp_ext   = {{(SW-PPW){pp[PPW-1]}}, pp};
        shamt    = int'(cnt_q) * D;
        // Anything above bit 2*WIDTH-1 is discarded by the final truncation anyway
        pp_shift = PW'(pp_ext << shamt);
        acc_nxt  = acc_q + pp_shift;
        // Arithmetic shift keeps the extension bits consistent for the next window
        bx_nxt   = $signed(bx_q) >>> D;
        bx_load  = {{(NB-WIDTH){Signed & B[WIDTH-1]}}, B, 1'b0};
        a_load   = {Signed & A[WIDTH-1], A};
        last_digit = (cnt_q == CW'(N - 1));
`ifdef BOOTH_ZERO_SKIP_EN
        // Remaining bits all equal means every later digit recodes to zero
        finish_now = last_digit | (&bx_nxt) | ~(|bx_nxt);
`else
        finish_now = last_digit;
`endif
    end

    // Controller plus datapath: capture on accepted Start, retire one digit per RUN cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bx_q      <= '0;
            a_ext_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    if (Start) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        bx_q    <= bx_load;
                        a_ext_q <= a_load;
                        acc_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_nxt;
                    bx_q  <= bx_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (finish_now) begin
                        state_q   <= ST_FINISH;
                        product_q <= acc_nxt;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy    = (state_q == ST_RUN);
    assign Done    = (state_q == ST_FINISH);
    assign Product = product_q;

endmodule
